// File: rtl/rx_core_config_ctrl.sv
// Shadow/commit configuration controller for rx_core.
// Phase increments are retuned only while the DUC gains are muted.
// Gains are ramped toward their targets in bounded steps.
module rx_core_config_ctrl #(
    parameter int unsigned GAIN_STEP     = 8,
    parameter int unsigned SETTLE_CYCLES = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_err,
    input  logic        commit_valid,
    output logic        commit_ready,
    output logic [15:0] ddc_phase_inc,
    output logic [15:0] demix_phase_inc,
    output logic [15:0] duc_phase_inc,
    output logic [7:0]  gain_duc1,
    output logic [7:0]  gain_duc2,
    output logic [7:0]  gain_duc3,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_MUTE, S_APPLY, S_SETTLE, S_RAMP} state_t;

    localparam logic [7:0]  STEP8       = 8'(GAIN_STEP);
    localparam logic [8:0]  STEP9       = 9'(GAIN_STEP);
    localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        active_q;                 // low until the first edge after reset release
    logic        done_q, done_d;
    logic        wr_err_q, wr_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] shadow_phase_q [3];
    logic [15:0] shadow_phase_d [3];
    logic [7:0]  shadow_gain_q  [3];
    logic [7:0]  shadow_gain_d  [3];
    logic [15:0] pend_phase_q   [3];
    logic [15:0] pend_phase_d   [3];
    logic [7:0]  pend_gain_q    [3];
    logic [7:0]  pend_gain_d    [3];
    logic [15:0] phase_q        [3];
    logic [15:0] phase_d        [3];
    logic [7:0]  gain_q         [3];
    logic [7:0]  gain_d         [3];
    logic [7:0]  mute_val       [3];
    logic [7:0]  ramp_val       [3];

    logic accept;
    logic phase_change;
    logic gains_zero;
    logic gains_at_target;

    assign wr_ready        = 1'b1;
    assign commit_ready    = (state_q == S_IDLE) && active_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign wr_err          = wr_err_q;
    assign ddc_phase_inc   = phase_q[0];
    assign demix_phase_inc = phase_q[1];
    assign duc_phase_inc   = phase_q[2];
    assign gain_duc1       = gain_q[0];
    assign gain_duc2       = gain_q[1];
    assign gain_duc3       = gain_q[2];

    assign accept          = commit_valid && commit_ready;
    assign phase_change    = (shadow_phase_q[0] != phase_q[0]) ||
                             (shadow_phase_q[1] != phase_q[1]) ||
                             (shadow_phase_q[2] != phase_q[2]);
    assign gains_zero      = (gain_q[0] == 8'd0) && (gain_q[1] == 8'd0) && (gain_q[2] == 8'd0);
    assign gains_at_target = (gain_q[0] == pend_gain_q[0]) && (gain_q[1] == pend_gain_q[1]) &&
                             (gain_q[2] == pend_gain_q[2]);

    // Per-gain step arithmetic: 9-bit distance so neither direction can wrap or overshoot.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_gain_step
            logic [8:0] cur9, tgt9, dist9;
            assign cur9  = {1'b0, gain_q[gi]};
            assign tgt9  = {1'b0, pend_gain_q[gi]};
            assign dist9 = (tgt9 >= cur9) ? (tgt9 - cur9) : (cur9 - tgt9);
            assign mute_val[gi] = (cur9 > STEP9) ? (gain_q[gi] - STEP8) : 8'd0;
            assign ramp_val[gi] = (dist9 <= STEP9) ? pend_gain_q[gi] :
                                  (tgt9 > cur9)    ? (gain_q[gi] + STEP8) :
                                                     (gain_q[gi] - STEP8);
        end
    endgenerate

    // Shadow register writes and bad-address flag; accepted in every state.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            shadow_phase_d[i] = shadow_phase_q[i];
            shadow_gain_d[i]  = shadow_gain_q[i];
        end
        wr_err_d = 1'b0;
        if (wr_valid) begin
            case (wr_addr)
                4'd0:    shadow_phase_d[0] = wr_data;
                4'd1:    shadow_phase_d[1] = wr_data;
                4'd2:    shadow_phase_d[2] = wr_data;
                4'd3:    shadow_gain_d[0]  = wr_data[7:0];
                4'd4:    shadow_gain_d[1]  = wr_data[7:0];
                4'd5:    shadow_gain_d[2]  = wr_data[7:0];
                default: wr_err_d          = 1'b1;
            endcase
        end
    end

    // Commit sequencer: next state, pending capture, phase load, gain mute/ramp.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pend_phase_d[i] = pend_phase_q[i];
            pend_gain_d[i]  = pend_gain_q[i];
            phase_d[i]      = phase_q[i];
            gain_d[i]       = gain_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    for (int i = 0; i < 3; i++) begin
                        pend_phase_d[i] = shadow_phase_q[i];
                        pend_gain_d[i]  = shadow_gain_q[i];
                    end
                    state_d = phase_change ? S_MUTE : S_RAMP;
                end
            end
            S_MUTE: begin
                if (gains_zero) begin
                    state_d = S_APPLY;
                end else begin
                    for (int i = 0; i < 3; i++) gain_d[i] = mute_val[i];
                end
            end
            S_APPLY: begin
                for (int i = 0; i < 3; i++) phase_d[i] = pend_phase_q[i];
                cnt_d   = SETTLE_INIT;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_RAMP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RAMP: begin
                if (gains_at_target) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    for (int i = 0; i < 3; i++) gain_d[i] = ramp_val[i];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any sequence immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            cnt_q    <= 16'd0;
            for (int i = 0; i < 3; i++) begin
                shadow_phase_q[i] <= 16'd0;
                shadow_gain_q[i]  <= 8'd0;
                pend_phase_q[i]   <= 16'd0;
                pend_gain_q[i]    <= 8'd0;
                phase_q[i]        <= 16'd0;
                gain_q[i]         <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < 3; i++) begin
                shadow_phase_q[i] <= shadow_phase_d[i];
                shadow_gain_q[i]  <= shadow_gain_d[i];
                pend_phase_q[i]   <= pend_phase_d[i];
                pend_gain_q[i]    <= pend_gain_d[i];
                phase_q[i]        <= phase_d[i];
                gain_q[i]         <= gain_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rx_core_config_ctrl.sv
// Directed bench for rx_core_config_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_rx_core_config_ctrl;

    localparam int GAIN_STEP     = 8;
    localparam int SETTLE_CYCLES = 64;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = 4'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_err;
    logic        commit_valid = 1'b0;
    logic        commit_ready;
    logic [15:0] ddc_phase_inc, demix_phase_inc, duc_phase_inc;
    logic [7:0]  gain_duc1, gain_duc2, gain_duc3;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    rx_core_config_ctrl #(.GAIN_STEP(GAIN_STEP), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
        .clock(clock), .resetn(resetn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .commit_valid(commit_valid), .commit_ready(commit_ready),
        .ddc_phase_inc(ddc_phase_inc), .demix_phase_inc(demix_phase_inc),
        .duc_phase_inc(duc_phase_inc), .gain_duc1(gain_duc1), .gain_duc2(gain_duc2),
        .gain_duc3(gain_duc3), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wv;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        cv;
        logic [7:0]  g;
        logic [15:0] ddc;
        logic        bsy;
        logic        dn;
        logic        crdy;
        logic        werr;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clock);
        #1;
        if (done) done_seen++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_gains(input string name, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3);
        chk({name, "_g1"}, {8'd0, gain_duc1}, {8'd0, e1});
        chk({name, "_g2"}, {8'd0, gain_duc2}, {8'd0, e2});
        chk({name, "_g3"}, {8'd0, gain_duc3}, {8'd0, e3});
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
    endtask

    function automatic logic [7:0] step_toward(input logic [7:0] c, input logic [7:0] t);
        int d;
        d = int'(t) - int'(c);
        if (d > GAIN_STEP) return 8'(int'(c) + GAIN_STEP);
        if (d < -GAIN_STEP) return 8'(int'(c) - GAIN_STEP);
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m1, m2, m3;
        logic       nonzero;
        logic       got;
        int         n;
        int         done_before;

        // Reset state, sampled before any clock edge has been seen.
        #3;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_crdy", {15'd0, commit_ready}, 16'd0);
        chk("rst_wr_ready", {15'd0, wr_ready}, 16'd1);
        chk("rst_ddc", ddc_phase_inc, 16'd0);
        chk_gains("rst", 8'd0, 8'd0, 8'd0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        chk("post_rst_crdy", {15'd0, commit_ready}, 16'd1);

        // Gain-only commit, bad address, and a commit pulse while busy.
        vecs[0]  = '{1'b1, 4'd3, 16'h0020, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'd4, 16'h0020, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 4'd5, 16'h0020, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'd9, 16'hFFFF, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 8'h08, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h18, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            commit_valid = vecs[i].cv;
            tick();
            $display("vec %0d: wv=%0d wa=%0d cv=%0d -> g=%h/%h/%h busy=%0d done=%0d werr=%0d",
                     i, vecs[i].wv, vecs[i].wa, vecs[i].cv, gain_duc1, gain_duc2, gain_duc3,
                     busy, done, wr_err);
            chk_gains($sformatf("vec%0d", i), vecs[i].g, vecs[i].g, vecs[i].g);
            chk($sformatf("vec%0d_ddc", i), ddc_phase_inc, vecs[i].ddc);
            chk($sformatf("vec%0d_demix", i), demix_phase_inc, 16'd0);
            chk($sformatf("vec%0d_busy", i), {15'd0, busy}, {15'd0, vecs[i].bsy});
            chk($sformatf("vec%0d_done", i), {15'd0, done}, {15'd0, vecs[i].dn});
            chk($sformatf("vec%0d_crdy", i), {15'd0, commit_ready}, {15'd0, vecs[i].crdy});
            chk($sformatf("vec%0d_werr", i), {15'd0, wr_err}, {15'd0, vecs[i].werr});
        end
        wr_valid = 1'b0; commit_valid = 1'b0;

        // Retune: mute, apply phase, settle 64 cycles, ramp back.
        write(4'd0, 16'h1234);
        chk("retune_ddc_shadow_only", ddc_phase_inc, 16'd0);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        $display("retune commit: busy=%0d g=%h", busy, gain_duc1);
        chk("retune_busy", {15'd0, busy}, 16'd1);
        chk_gains("retune_accept", 8'h20, 8'h20, 8'h20);
        m1 = 8'h20;
        for (int i = 0; i < 4; i++) begin
            m1 = m1 - 8'h08;
            tick();
            chk_gains($sformatf("mute%0d", i), m1, m1, m1);
            chk($sformatf("mute%0d_ddc", i), ddc_phase_inc, 16'd0);
        end
        tick();
        chk("to_apply_ddc", ddc_phase_inc, 16'd0);
        tick();
        chk("apply_ddc", ddc_phase_inc, 16'h1234);
        chk_gains("apply", 8'd0, 8'd0, 8'd0);
        nonzero = 1'b0;
        for (int i = 0; i < SETTLE_CYCLES; i++) begin
            tick();
            if (gain_duc1 != 0 || gain_duc2 != 0 || gain_duc3 != 0 || !busy) nonzero = 1'b1;
        end
        chk("settle_gains_zero", {15'd0, nonzero}, 16'd0);
        m1 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            m1 = m1 + 8'h08;
            tick();
            chk_gains($sformatf("rampup%0d", i), m1, m1, m1);
        end
        tick();
        $display("retune end: busy=%0d done=%0d ddc=%h", busy, done, ddc_phase_inc);
        chk("retune_done", {15'd0, done}, 16'd1);
        chk("retune_idle", {15'd0, busy}, 16'd0);
        chk("retune_ddc_final", ddc_phase_inc, 16'h1234);
        chk("done_count_2", 16'(done_seen), 16'd2);

        // Set up asymmetric starting gains 05/FF/00 (no phase change, direct ramp).
        write(4'd3, 16'h0005);
        write(4'd4, 16'h00FF);
        write(4'd5, 16'h0000);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (done) got = 1'b1;
        end
        chk("setup_done", {15'd0, got}, 16'd1);
        chk_gains("setup", 8'h05, 8'hFF, 8'h00);

        // Asymmetric ramp with a duc write in the accept cycle and a commit pulse while busy.
        write(4'd3, 16'h00FF);
        write(4'd4, 16'h0003);
        write(4'd5, 16'h0000);
        commit_valid = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 16'h0ABC;
        tick();
        commit_valid = 1'b0;
        wr_valid = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
        chk("asym_busy", {15'd0, busy}, 16'd1);
        chk_gains("asym_accept", 8'h05, 8'hFF, 8'h00);
        m1 = 8'h05; m2 = 8'hFF; m3 = 8'h00;
        n = 0;
        while ((m1 != 8'hFF || m2 != 8'h03 || m3 != 8'h00) && n < 60) begin
            m1 = step_toward(m1, 8'hFF);
            m2 = step_toward(m2, 8'h03);
            m3 = step_toward(m3, 8'h00);
            commit_valid = (n == 5);
            tick();
            chk_gains($sformatf("asym%0d", n), m1, m2, m3);
            n++;
        end
        commit_valid = 1'b0;
        chk("asym_ramp_len", 16'(n), 16'd32);
        tick();
        $display("asym end: g=%h/%h/%h busy=%0d done=%0d duc=%h", gain_duc1, gain_duc2,
                 gain_duc3, busy, done, duc_phase_inc);
        chk("asym_done", {15'd0, done}, 16'd1);
        chk("asym_idle", {15'd0, busy}, 16'd0);
        chk("asym_duc_excluded", duc_phase_inc, 16'd0);
        chk("done_count_4", 16'(done_seen), 16'd4);

        // Next commit picks up the duc write; then reset lands in SETTLE.
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (duc_phase_inc == 16'h0ABC) got = 1'b1;
        end
        chk("duc_applied", {15'd0, got}, 16'd1);
        chk_gains("duc_apply", 8'd0, 8'd0, 8'd0);
        chk("duc_apply_busy", {15'd0, busy}, 16'd1);
        for (int i = 0; i < 5; i++) tick();
        done_before = done_seen;
        #2;
        resetn = 1'b0;
        #1;
        $display("async reset: busy=%0d duc=%h ddc=%h g=%h", busy, duc_phase_inc,
                 ddc_phase_inc, gain_duc2);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        chk("arst_crdy", {15'd0, commit_ready}, 16'd0);
        chk("arst_ddc", ddc_phase_inc, 16'd0);
        chk("arst_duc", duc_phase_inc, 16'd0);
        chk("arst_wr_ready", {15'd0, wr_ready}, 16'd1);
        chk_gains("arst", 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        @(negedge clock);
        resetn = 1'b1;
        tick();
        chk("rel_busy", {15'd0, busy}, 16'd0);
        chk("rel_crdy", {15'd0, commit_ready}, 16'd1);
        chk("rel_ddc", ddc_phase_inc, 16'd0);
        for (int i = 0; i < 80; i++) tick();
        chk("no_done_after_reset", 16'(done_seen - done_before), 16'd0);

        // Shadows cleared by reset: an empty commit goes straight RAMP -> IDLE.
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        chk("empty_commit_busy", {15'd0, busy}, 16'd1);
        tick();
        chk("empty_commit_done", {15'd0, done}, 16'd1);
        chk("empty_commit_duc", duc_phase_inc, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_core_config_ctrl.md
RX_CORE_CONFIG_CTRL -- requirements
Module: rx_core_config_ctrl

Interface
REQ-001 SHALL have parameter GAIN_STEP, default 8, maximum gain change per clock during ramps (legal 1..255).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 64, NCO settle wait after a phase update (legal 1..65535).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clock  input  1  sole clock; all logic on its rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 wr_valid  input  1  shadow-register write strobe; wr_ready is constant 1.
REQ-007 wr_ready  output  1  tied high.
REQ-008 wr_addr  input  4  0=ddc_phase, 1=demix_phase, 2=duc_phase, 3=gain1, 4=gain2, 5=gain3.
REQ-009 wr_data  input  16  write data; gain addresses use bits [7:0].
REQ-010 wr_err  output  1  one-cycle pulse, cycle after a write to address 6..15.
REQ-011 commit_valid  input  1  request to apply shadow registers.
REQ-012 commit_ready  output  1  high only in IDLE.
REQ-013 ddc_phase_inc, demix_phase_inc, duc_phase_inc  output  16 each  registered NCO increments to rx_core.
REQ-014 gain_duc1, gain_duc2, gain_duc3  output  8 each  registered DUC gains to rx_core.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 done  output  1  one-cycle pulse on completion of a commit sequence.

Function
REQ-017 Writes with wr_valid high and address 0..5 SHALL update the addressed shadow register next edge in any state; they do not affect outputs until a later commit.
REQ-018 A commit SHALL be accepted when commit_valid && commit_ready; accepting copies all six shadow registers into pending registers.
REQ-019 A write in the same cycle as an accepted commit SHALL NOT be included in that commit; it lands in shadow for the next commit.
REQ-020 commit_valid while busy SHALL be ignored, with no queuing.
REQ-021 States: IDLE, MUTE, APPLY, SETTLE, RAMP.
REQ-022 IDLE -> MUTE on accept if any pending phase differs from its current output; otherwise IDLE -> RAMP.
REQ-023 MUTE: each cycle, every gain output SHALL decrement by GAIN_STEP, saturating at 0; when all three registered gains are 0 at the start of a cycle, go to APPLY with no change that cycle.
REQ-024 APPLY: for exactly one cycle, all three phase outputs SHALL load pending values simultaneously and the settle counter loads SETTLE_CYCLES-1; then go to SETTLE.
REQ-025 SETTLE: the counter SHALL decrement each cycle; at counter 0, go to RAMP.
REQ-026 RAMP: each gain SHALL move toward its pending target by min(GAIN_STEP, |target-current|), up or down, with no overshoot or wrap; when all three registered gains equal their targets, go to IDLE.
REQ-027 done SHALL be high in the first IDLE cycle after RAMP, and only then.
REQ-028 Phase outputs SHALL change only in APPLY; gains SHALL be 0 throughout APPLY and SETTLE.
REQ-029 Arithmetic SHALL be unsigned 9-bit internally for ramps, with results clamped to 0..255.

Reset
REQ-030 While resetn is low, all outputs except wr_ready SHALL be 0, and shadow, pending, counter and state (IDLE) SHALL clear.
REQ-031 Reset asserted mid-sequence SHALL abort immediately; after release, the block SHALL be in IDLE with outputs 0 and no done pulse.
REQ-032 Logic SHALL leave reset synchronously on the first clock edge after resetn rises.

Verification
REQ-033 Gain-only commit: from reset, write gain1/2/3=0x20 and commit -> gains 0x08,0x10,0x18,0x20 on consecutive cycles; phases stay 0; one done pulse; never MUTE.
REQ-034 Retune: with gains 0x20, write ddc_phase=0x1234 and commit -> gains 0x18,0x10,0x08,0x00; ddc_phase_inc becomes 0x1234 only after gains are 0; gains stay 0 for 64 SETTLE cycles; gains ramp back to 0x20; done once.
REQ-035 Asymmetric ramp: gains 0x05/0xFF/0x00 with targets 0xFF/0x03/0x00 and GAIN_STEP=8 -> no wrap or overshoot; final gains 0xFF/0x03/0x00; RAMP ends only when all three match.
REQ-036 Busy/collision: commit_valid pulsed while busy -> ignored, exactly one done; write to addr 2 in the commit-accept cycle -> excluded, applied by the next commit.
REQ-037 Bad address: write to addr 9 -> wr_err pulses one cycle, shadows unchanged.
REQ-038 Reset in SETTLE: assert resetn low -> all outputs 0 asynchronously; after release, IDLE, commit_ready=1, done never pulses.
